// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32 M-extension DIV/DIVU/REM/REMU.
// One quotient bit per cycle. A divide-by-zero or signed overflow skips the
// iteration and produces the RISC-V defined result. The result is held on res
// with ready high for READY_HOLD cycles.
module divider #(
  parameter int XLEN       = 32,
  parameter int READY_HOLD = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);
  localparam int HW = $clog2(READY_HOLD + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_reg, state_next;
  logic            ready_reg, ready_next;
  logic [XLEN-1:0] res_reg, res_next;

  logic            is_rem_reg;
  logic            neg_q_reg, neg_r_reg;
  logic            div0_reg, ovf_reg;
  logic [XLEN-1:0] a_raw_reg;
  logic [XLEN-1:0] divisor_reg;
  logic [XLEN-1:0] rem_reg, quo_reg;
  logic [CW-1:0]   cnt_reg;
  logic [HW-1:0]   hold_reg;

  // Decode of the select input; 101-111 behave like "none".
  logic op_valid, op_signed, op_rem;
  assign op_valid  = (divsel >= 3'd1) && (divsel <= 3'd4);
  assign op_signed = (divsel == 3'd1) || (divsel == 3'd3);
  assign op_rem    = (divsel == 3'd3) || (divsel == 3'd4);

  // Operand magnitudes and special-case detection for the capture cycle.
  logic [XLEN-1:0] a_abs, b_abs;
  logic            in_div0, in_ovf;
  assign a_abs   = (op_signed && a[XLEN-1]) ? -a : a;
  assign b_abs   = (op_signed && b[XLEN-1]) ? -b : b;
  assign in_div0 = (b == '0);
  assign in_ovf  = op_signed && (a == MIN_NEG) && (b == '1);

  // One restoring step: shift {rem,quo} left, try subtracting the divisor.
  // A non-negative trial is always below the divisor, so any set bit above
  // XLEN-1 means the subtraction went negative.
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;
  logic            trial_neg;
  assign rem_sh    = {rem_reg, quo_reg[XLEN-1]};
  assign trial     = {1'b0, rem_sh} - {2'b00, divisor_reg};
  assign trial_neg = |trial[XLEN+1:XLEN];

  // Final result selection applied in the FIX cycle.
  logic [XLEN-1:0] fix_result;
  always_comb begin
    fix_result = '0;
    if (div0_reg)
      fix_result = is_rem_reg ? a_raw_reg : '1;
    else if (ovf_reg)
      fix_result = is_rem_reg ? '0 : MIN_NEG;
    else if (is_rem_reg)
      fix_result = neg_r_reg ? -rem_reg : rem_reg;
    else
      fix_result = neg_q_reg ? -quo_reg : quo_reg;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic, including abort when the select drops mid-op.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (op_valid) state_next = (in_div0 || in_ovf) ? FIX : CALC;
      CALC: begin
        if (!op_valid)                        state_next = IDLE;
        else if (cnt_reg == CW'(XLEN - 1))    state_next = FIX;
      end
      FIX:  state_next = op_valid ? DONE : IDLE;
      DONE: if (hold_reg == HW'(READY_HOLD)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: res loads only in a non-aborted FIX, ready is high during hold.
  always_comb begin
    ready_next = 1'b0;
    res_next   = res_reg;
    case (state_reg)
      FIX:     if (op_valid) res_next = fix_result;
      DONE:    ready_next = (hold_reg < HW'(READY_HOLD));
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_reg <= 1'b0;
      res_reg   <= '0;
    end else begin
      ready_reg <= ready_next;
      res_reg   <= res_next;
    end
  end

  // Datapath: operand capture, iteration and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_rem_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      div0_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      a_raw_reg   <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      hold_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (op_valid) begin
            is_rem_reg  <= op_rem;
            neg_q_reg   <= op_signed && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_reg   <= op_signed && a[XLEN-1];
            div0_reg    <= in_div0;
            ovf_reg     <= in_ovf;
            a_raw_reg   <= a;
            divisor_reg <= b_abs;
            rem_reg     <= '0;
            quo_reg     <= a_abs;
            cnt_reg     <= '0;
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (!trial_neg) begin
            rem_reg <= trial[XLEN-1:0];
            quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
          end else begin
            rem_reg <= rem_sh[XLEN-1:0];
            quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
          end
        end
        FIX:  hold_reg <= '0;
        DONE: if (hold_reg < HW'(READY_HOLD)) hold_reg <= hold_reg + 1'b1;
        default: ;
      endcase
    end
  end

  assign ready = ready_reg;
  assign res   = res_reg;

endmodule

// File: tb/tb_divider.sv
// Bench for divider: table of operations with expected result and latency,
// a scoreboard queue of expected results, plus hand-written sequences for
// abort, reset mid-op and back-to-back operation.
module tb_divider;

  logic        clk;
  logic        rst;
  logic [2:0]  divsel;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic [31:0] res;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  localparam logic [2:0] NONE = 3'd0, DIV = 3'd1, DIVU = 3'd2, REM = 3'd3, REMU = 3'd4;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[20];

  divider dut (
    .clk(clk), .rst(rst), .divsel(divsel), .a(a), .b(b), .ready(ready), .res(res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Drive one op, scramble a/b after capture, wait for ready, check result,
  // latency and the hold window, then release divsel.
  task automatic run_op(input logic [2:0] sel, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] er, input int el);
    int n;
    bit found;
    logic [31:0] e;
    int l;
    @(negedge clk);
    divsel = sel; a = va; b = vb;
    exp_q.push_back(er);
    lat_q.push_back(el);
    @(posedge clk);
    @(negedge clk);
    a = $urandom; b = $urandom;
    n = 1;
    found = 0;
    @(posedge clk); #1;
    while (!found && n < 100) begin
      if (ready) found = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!found) begin
      checks++; errors++;
      $display("FAIL timeout: ready not seen within %0d edges for sel=%0d", n, sel);
    end else begin
      check("res", res, e);
      check("latency", 32'(n), 32'(l));
      $display("op sel=%0d a=0x%08h b=0x%08h res=0x%08h lat=%0d", sel, va, vb, res, n);
      @(negedge clk);
      divsel = NONE;
      @(posedge clk); #1;
      check("ready_hold2", {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
      check("ready_fall", {31'd0, ready}, 32'd0);
      check("res_stable", res, e);
    end
  endtask

  initial begin
    int n;
    bit seen_low;
    bit got;

    vecs[0]  = '{DIVU, 32'd100,        32'd7,        32'd14,         34};
    vecs[1]  = '{REMU, 32'd100,        32'd7,        32'd2,          34};
    vecs[2]  = '{REM,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF,   34};
    vecs[3]  = '{DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,   34};
    vecs[4]  = '{DIV,  32'd5,          32'd0,        32'hFFFFFFFF,   2};
    vecs[5]  = '{REMU, 32'hDEADBEEF,   32'd0,        32'hDEADBEEF,   2};
    vecs[6]  = '{DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000,   2};
    vecs[7]  = '{REM,  32'h80000000,   32'hFFFFFFFF, 32'd0,          2};
    vecs[8]  = '{DIVU, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,   34};
    vecs[9]  = '{REM,  32'd7,          32'hFFFFFFFE, 32'd1,          34};
    vecs[10] = '{DIV,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   34};
    vecs[11] = '{DIVU, 32'h80000000,   32'd3,        32'h2AAAAAAA,   34};
    vecs[12] = '{REMU, 32'h80000000,   32'd3,        32'd2,          34};
    vecs[13] = '{DIVU, 32'd5,          32'd0,        32'hFFFFFFFF,   2};
    vecs[14] = '{REM,  32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB,   2};
    vecs[15] = '{DIVU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,          34};
    vecs[16] = '{DIV,  32'h80000000,   32'd1,        32'h80000000,   34};
    vecs[17] = '{DIVU, 32'd3,          32'd7,        32'd0,          34};
    vecs[18] = '{REM,  32'hFFFFFFF6,   32'd3,        32'hFFFFFFFF,   34};
    vecs[19] = '{DIVU, 32'd100,        32'd7,        32'd14,         34};

    rst = 1'b1; divsel = NONE; a = '0; b = '0;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_res", res, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);

    // Abort: divsel drops to none so that edge 10 samples it; res keeps 14.
    @(negedge clk);
    divsel = DIVU; a = 32'd1000; b = 32'd10;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    divsel = NONE;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) got = 1;
    end
    check("abort_no_ready", {31'd0, got}, 32'd0);
    check("abort_res_kept", res, 32'd14);
    $display("abort sequence res=0x%08h", res);
    run_op(DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Reset asserted between edges while in CALC.
    @(negedge clk);
    divsel = DIV; a = 32'd77; b = 32'd5;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_res", res, 32'd0);
    $display("reset mid-op res=0x%08h ready=%0d", res, ready);
    @(negedge clk);
    rst = 1'b0; divsel = NONE;
    run_op(DIV, 32'hFFFFFFF6, 32'd3, 32'hFFFFFFFD, 34);

    // Back-to-back: divsel held; ready must repeat every 37 edges.
    @(negedge clk);
    divsel = DIVU; a = 32'hFFFFFFFF; b = 32'd1;
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready) got = 1;
    end
    check("b2b_first_seen", {31'd0, got}, 32'd1);
    check("b2b_first_res", res, 32'hFFFFFFFF);
    n = 0;
    seen_low = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!ready) seen_low = 1;
      else if (seen_low) got = 1;
    end
    check("b2b_period", 32'(n), 32'd37);
    check("b2b_second_res", res, 32'hFFFFFFFF);
    $display("back-to-back period=%0d res=0x%08h", n, res);
    @(negedge clk);
    divsel = NONE;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_idle_ready", {31'd0, ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
